// File: rtl/param_bank_pkg.sv
// param_bank_pkg: shared types and constants for the parameter bank.
//   - channel index constants for the synth settings bank
//   - key direction and repeat FSM state enums
//   - default auto-repeat timing (50 MHz clock)
package param_bank_pkg;

    localparam int unsigned PARAM_AMPLITUDE = 0;
    localparam int unsigned PARAM_ATTACK    = 1;
    localparam int unsigned PARAM_DECAY     = 2;
    localparam int unsigned PARAM_SUSTAIN   = 3;
    localparam int unsigned PARAM_RELEASE   = 4;

    localparam int unsigned DEF_REPEAT_DELAY  = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD = 2500000;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } rep_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/param_bank_if.sv
// param_bank_if: key/load inputs and channel outputs of the parameter bank.
//   sel, inc, dec, load_en, load_val : driven by the key decoder (master)
//   params, step_pulse, at_limit     : driven by param_bank (slave)
interface param_bank_if #(
    parameter int unsigned NUM_PARAMS = 5,
    parameter int unsigned PARAM_W    = 31,
    parameter int unsigned SEL_W      = 3
);
    logic [SEL_W-1:0]                sel;
    logic                            inc;
    logic                            dec;
    logic                            load_en;
    logic [PARAM_W-1:0]              load_val;
    logic [NUM_PARAMS*PARAM_W-1:0]   params;
    logic                            step_pulse;
    logic                            at_limit;

    modport master (
        output sel, inc, dec, load_en, load_val,
        input  params, step_pulse, at_limit
    );

    modport slave (
        input  sel, inc, dec, load_en, load_val,
        output params, step_pulse, at_limit
    );
endinterface

// File: rtl/param_bank_key_repeat.sv
// param_bank_key_repeat: turns a held key direction into step strobes
// (one on press, then auto-repeat after a delay at a fixed period).
//   clk, rst_n      : clock, async active-low reset
//   i_dir           : current key direction
//   i_sel_changed   : channel selector differs from the previous cycle
//   o_step_c        : combinational step strobe for the current edge
//   o_dir_c         : direction of that step
module param_bank_key_repeat
    import param_bank_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  dir_e i_dir,
    input  logic i_sel_changed,
    output logic o_step_c,
    output dir_e o_dir_c
);

    localparam int unsigned CNT_RAW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam int unsigned CNT_W   = (CNT_RAW == 0) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_e       r_state;
    rep_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    dir_e             r_dir;
    dir_e             w_dir_nxt;

    // The press step must land on the same edge the key is first seen,
    // so the strobe is decoded from the current state and inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        o_step_c    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_dir != DIR_NONE) begin
                    o_step_c    = 1'b1;
                    w_state_nxt = ST_DELAY;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = i_dir;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (i_dir == DIR_NONE) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = DIR_NONE;
                end else if (i_sel_changed) begin
                    // held key must be released before the new channel moves
                    w_state_nxt = ST_WAIT_REL;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = DIR_NONE;
                end else if (i_dir != r_dir) begin
                    // reversal behaves as a fresh press
                    o_step_c    = 1'b1;
                    w_state_nxt = ST_DELAY;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = i_dir;
                end else if (r_state == ST_DELAY) begin
                    if (r_cnt == DELAY_LAST) begin
                        o_step_c    = 1'b1;
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt == PERIOD_LAST) begin
                        o_step_c  = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_WAIT_REL: begin
                if (i_dir == DIR_NONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_dir_nxt   = DIR_NONE;
            end
        endcase
    end

    assign o_dir_c = i_dir;

    // State, counter and latched direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

endmodule

// File: rtl/param_bank.sv
// param_bank: bank of NUM_PARAMS user-adjustable settings with saturating
// +/- steps, timed auto-repeat and a direct-load path.  A second instance
// with NUM_PARAMS=1, PARAM_W=3, STEP=1, MAX_VAL=7, DEFAULTS=4 serves as
// the octave register.
//   clk       : system clock
//   reset     : async active-low reset
//   bus.sel/inc/dec/load_en/load_val : channel select, key levels, load
//   bus.params     : all channel values, channel i at [i*PARAM_W +: PARAM_W]
//   bus.step_pulse : one cycle after any channel value actually changed
//   bus.at_limit   : sel channel sits at MIN_VAL or MAX_VAL (one cycle late)
module param_bank
    import param_bank_pkg::*;
#(
    parameter int unsigned NUM_PARAMS    = 5,
    parameter int unsigned PARAM_W       = 31,
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned STEP          = 10,
    parameter logic [PARAM_W-1:0] MIN_VAL = '0,
    parameter logic [PARAM_W-1:0] MAX_VAL = PARAM_W'(1073741824),
    parameter logic [NUM_PARAMS*PARAM_W-1:0] DEFAULTS = {NUM_PARAMS{PARAM_W'(1073741824)}},
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic          clk,
    input  logic          reset,
    param_bank_if.slave   bus
);

    localparam int unsigned EXT_W = PARAM_W + 1;
    localparam logic [EXT_W-1:0] MAX_EXT      = {1'b0, MAX_VAL};
    localparam logic [EXT_W-1:0] MIN_PLUS_EXT = {1'b0, MIN_VAL} + EXT_W'(STEP);

    logic [PARAM_W-1:0] r_params [NUM_PARAMS];
    logic [SEL_W-1:0]   r_sel_prev;
    logic               r_step_pulse;
    logic               r_at_limit;

    dir_e               w_dir;
    logic               w_step;
    dir_e               w_step_dir;
    logic               w_sel_valid;
    logic [PARAM_W-1:0] w_old;
    logic [EXT_W-1:0]   w_up_ext;
    logic [PARAM_W-1:0] w_stepped;
    logic [PARAM_W-1:0] w_load_clamped;
    logic [PARAM_W-1:0] w_new;
    logic               w_wr;

    // Both keys held cancels out.
    always_comb begin
        w_dir = DIR_NONE;
        if (bus.inc && !bus.dec) begin
            w_dir = DIR_UP;
        end else if (bus.dec && !bus.inc) begin
            w_dir = DIR_DN;
        end
    end

    param_bank_key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_key_repeat (
        .clk           (clk),
        .rst_n         (reset),
        .i_dir         (w_dir),
        .i_sel_changed (bus.sel != r_sel_prev),
        .o_step_c      (w_step),
        .o_dir_c       (w_step_dir)
    );

    // Selected channel value; out-of-range selectors read as zero.
    always_comb begin
        w_sel_valid = (32'(bus.sel) < NUM_PARAMS);
        w_old       = '0;
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
            if (32'(bus.sel) == i) begin
                w_old = r_params[i];
            end
        end
    end

    // Saturating step at PARAM_W+1 bits and clamped load; load wins.
    always_comb begin
        w_up_ext  = {1'b0, w_old} + EXT_W'(STEP);
        w_stepped = w_old;
        if (w_step_dir == DIR_UP) begin
            w_stepped = (w_up_ext > MAX_EXT) ? MAX_VAL : w_up_ext[PARAM_W-1:0];
        end else if (w_step_dir == DIR_DN) begin
            w_stepped = ({1'b0, w_old} < MIN_PLUS_EXT) ? MIN_VAL : (w_old - PARAM_W'(STEP));
        end

        w_load_clamped = bus.load_val;
        if (bus.load_val < MIN_VAL) begin
            w_load_clamped = MIN_VAL;
        end else if (bus.load_val > MAX_VAL) begin
            w_load_clamped = MAX_VAL;
        end

        w_new = bus.load_en ? w_load_clamped : w_stepped;
        w_wr  = w_sel_valid && (bus.load_en || w_step);
    end

    // Channel registers, selector history, pulse and limit flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                r_params[i] <= DEFAULTS[i*PARAM_W +: PARAM_W];
            end
            r_sel_prev   <= '0;
            r_step_pulse <= 1'b0;
            r_at_limit   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                if (w_wr && (32'(bus.sel) == i)) begin
                    r_params[i] <= w_new;
                end
            end
            r_sel_prev   <= bus.sel;
            r_step_pulse <= w_wr && (w_new != w_old);
            r_at_limit   <= w_sel_valid && ((w_old == MIN_VAL) || (w_old == MAX_VAL));
        end
    end

    always_comb begin
        bus.params = '0;
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
            bus.params[i*PARAM_W +: PARAM_W] = r_params[i];
        end
    end

    assign bus.step_pulse = r_step_pulse;
    assign bus.at_limit   = r_at_limit;

endmodule
